// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared widths and memory-op codes for the rvseed MEM stage.
// The load codes are read by the write-back mux. The store codes are read
// by the LSU lane aligner.
package lsu_ctrl_pkg;

  localparam int CPU_WIDTH    = 32;
  localparam int MEM_OP_WIDTH = 4;

  // 0 is reserved for "no op". It is the reset value of the registered op.
  localparam logic [MEM_OP_WIDTH-1:0] MEM_NONE = 4'd0;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LB   = 4'd1;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LH   = 4'd2;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LW   = 4'd3;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LBU  = 4'd4;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LHU  = 4'd5;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SB   = 4'd6;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SH   = 4'd7;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SW   = 4'd8;

endpackage

// File: rtl/lsu_store_align.sv
// lsu_store_align: combinational alignment check and store-lane generation.
//   op       in   memory op code
//   addr_lo  in   byte address bits [1:0]
//   wdata_i  in   low-aligned store data
//   wstrb    out  byte strobes (0 for loads)
//   wdata    out  store data replicated across byte lanes
//   misalign out  1 when the access crosses its natural alignment
module lsu_store_align
  import lsu_ctrl_pkg::*;
(
  input  logic [MEM_OP_WIDTH-1:0] op,
  input  logic [1:0]              addr_lo,
  input  logic [CPU_WIDTH-1:0]    wdata_i,
  output logic [3:0]              wstrb,
  output logic [CPU_WIDTH-1:0]    wdata,
  output logic                    misalign
);

  // NOTE: every output gets a default before the case so that no path leaves
  // a value unassigned, which would infer a latch.
  always_comb begin
    wstrb    = 4'b0000;
    wdata    = wdata_i;
    misalign = 1'b0;
    case (op)
      MEM_LH, MEM_LHU: misalign = addr_lo[0];
      MEM_LW:          misalign = |addr_lo;
      MEM_SB: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{wdata_i[7:0]}};
      end
      MEM_SH: begin
        misalign = addr_lo[0];
        wstrb    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata    = {2{wdata_i[15:0]}};
      end
      MEM_SW: begin
        misalign = |addr_lo;
        wstrb    = 4'hF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store controller.
// It accepts one op from EX and checks its alignment. It then runs a
// req/gnt/rvalid transaction on the data-memory port and returns the raw
// read word. Load extraction and sign/zero extension happen in the
// write-back mux.
//   EX side     : lsu_vld, lsu_flush, mem_wen, mem_op_i, addr_i, wdata_i
//   status      : lsu_busy, lsu_done, lsu_err, lsu_err_cause
//   memory port : dmem_req/we/addr/wstrb/wdata out; dmem_gnt/rvalid/rdata in
//   write-back  : mem_op, mem_addr, mem_rdata (held until the next accept)
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    lsu_vld,
  input  logic                    lsu_flush,
  input  logic                    mem_wen,
  input  logic [MEM_OP_WIDTH-1:0] mem_op_i,
  input  logic [CPU_WIDTH-1:0]    addr_i,
  input  logic [CPU_WIDTH-1:0]    wdata_i,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [CPU_WIDTH-1:0]    dmem_addr,
  output logic [3:0]              dmem_wstrb,
  output logic [CPU_WIDTH-1:0]    dmem_wdata,
  input  logic                    dmem_gnt,
  input  logic                    dmem_rvalid,
  input  logic [CPU_WIDTH-1:0]    dmem_rdata,
  output logic                    lsu_busy,
  output logic                    lsu_done,
  output logic                    lsu_err,
  output logic                    lsu_err_cause,
  output logic [MEM_OP_WIDTH-1:0] mem_op,
  output logic [CPU_WIDTH-1:0]    mem_addr,
  output logic [CPU_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_e;

  state_e               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 we_q, err_q, cause_q, kill_q;
  logic [3:0]           wstrb_q;
  logic [CPU_WIDTH-1:0] wdata_q;
  logic [3:0]           al_wstrb;
  logic [CPU_WIDTH-1:0] al_wdata;
  logic                 al_misalign;
  logic                 accept, timeout, to_err, in_bus;

  lsu_store_align u_align (
    .op       (mem_op_i),
    .addr_lo  (addr_i[1:0]),
    .wdata_i  (wdata_i),
    .wstrb    (al_wstrb),
    .wdata    (al_wdata),
    .misalign (al_misalign)
  );

  assign accept = (state == ST_IDLE) && lsu_vld && !lsu_flush;
  assign in_bus = (state == ST_REQ) || (state == ST_WAIT);
  // cnt counts the REQ/WAIT cycles already completed. The current cycle is
  // therefore the TIMEOUT_CYC-th one once cnt reaches TIMEOUT_CYC-1. The ">="
  // also covers a gnt taken in the last allowed REQ cycle, so cnt never wraps.
  assign timeout = (cnt >= CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt = state;
    to_err    = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = al_misalign ? ST_DONE : ST_REQ;
      ST_REQ: begin
        // Once granted, a response is owed; a flush can no longer abort.
        if (dmem_gnt)       state_nxt = ST_WAIT;
        else if (lsu_flush) state_nxt = ST_IDLE;
        else if (timeout) begin
          state_nxt = ST_DONE;
          to_err    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) state_nxt = ST_DONE;
        else if (timeout) begin
          state_nxt = ST_DONE;
          to_err    = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      cause_q   <= 1'b0;
      kill_q    <= 1'b0;
      wstrb_q   <= 4'b0000;
      wdata_q   <= '0;
      mem_op    <= MEM_NONE;
      mem_addr  <= '0;
      mem_rdata <= '0;
    end else if (accept) begin
      cnt      <= '0;
      we_q     <= mem_wen;
      err_q    <= al_misalign;
      cause_q  <= 1'b0;
      kill_q   <= 1'b0;
      wstrb_q  <= al_wstrb;
      wdata_q  <= al_wdata;
      mem_op   <= mem_op_i;
      mem_addr <= addr_i;
    end else begin
      if (in_bus) cnt <= cnt + 1'b1;
      if (to_err) begin
        err_q   <= 1'b1;
        cause_q <= 1'b1;
      end
      // A flush after gnt lets the transaction drain but silences completion.
      if (lsu_flush && in_bus) kill_q <= 1'b1;
      if ((state == ST_WAIT) && dmem_rvalid && !we_q) mem_rdata <= dmem_rdata;
    end
  end

  assign dmem_req      = (state == ST_REQ);
  assign dmem_we       = dmem_req && we_q;
  assign dmem_wstrb    = dmem_req ? wstrb_q : 4'b0000;
  assign dmem_wdata    = wdata_q;
  assign dmem_addr     = {mem_addr[CPU_WIDTH-1:2], 2'b00};
  assign lsu_busy      = (state != ST_IDLE);
  assign lsu_done      = (state == ST_DONE) && !kill_q && !lsu_flush;
  assign lsu_err       = lsu_done && err_q;
  assign lsu_err_cause = lsu_done && cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized and directed bench for lsu_ctrl, using a
// transaction-level reference model. The timeout is shortened to 8 cycles.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  localparam int TO = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    lsu_vld = 1'b0, lsu_flush = 1'b0, mem_wen = 1'b0;
  logic [MEM_OP_WIDTH-1:0] mem_op_i = '0;
  logic [CPU_WIDTH-1:0]    addr_i = '0, wdata_i = '0;
  logic                    dmem_req, dmem_we;
  logic [CPU_WIDTH-1:0]    dmem_addr, dmem_wdata;
  logic [3:0]              dmem_wstrb;
  logic                    dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [CPU_WIDTH-1:0]    dmem_rdata = '0;
  logic                    lsu_busy, lsu_done, lsu_err, lsu_err_cause;
  logic [MEM_OP_WIDTH-1:0] mem_op;
  logic [CPU_WIDTH-1:0]    mem_addr, mem_rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_rdata = '0;

  lsu_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .lsu_vld(lsu_vld), .lsu_flush(lsu_flush),
    .mem_wen(mem_wen), .mem_op_i(mem_op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .lsu_busy(lsu_busy),
    .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_err_cause(lsu_err_cause),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req"},   32'(dmem_req), 32'd0);
    check({pfx, "_we"},    32'(dmem_we), 32'd0);
    check({pfx, "_daddr"}, dmem_addr, 32'd0);
    check({pfx, "_strb"},  32'(dmem_wstrb), 32'd0);
    check({pfx, "_wdata"}, dmem_wdata, 32'd0);
    check({pfx, "_busy"},  32'(lsu_busy), 32'd0);
    check({pfx, "_done"},  32'(lsu_done), 32'd0);
    check({pfx, "_err"},   32'(lsu_err), 32'd0);
    check({pfx, "_cause"}, 32'(lsu_err_cause), 32'd0);
    check({pfx, "_op"},    32'(mem_op), 32'd0);
    check({pfx, "_maddr"}, mem_addr, 32'd0);
    check({pfx, "_rdata"}, mem_rdata, 32'd0);
  endtask

  function automatic bit is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic bit model_misalign(input logic [3:0] op, input logic [31:0] addr);
    int a = int'(addr % 4);
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return (a % 2) != 0;
    if (op == MEM_LW || op == MEM_SW) return a != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [3:0] op, input logic [31:0] addr);
    int a = int'(addr % 4);
    if (op == MEM_SB) return 4'(1 << a);
    if (op == MEM_SH) return 4'(3 << ((a / 2) * 2));
    if (op == MEM_SW) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] wd);
    logic [31:0] b = wd & 32'hFF;
    logic [31:0] h = wd & 32'hFFFF;
    if (op == MEM_SB) return b * 32'h01010101;
    if (op == MEM_SH) return h * 32'h00010001;
    return wd;
  endfunction

  // One op. Cycle 0 presents it while the DUT is idle; REQ/WAIT cycle k is
  // bench cycle k. gnt arrives in cycle 1+gnt_dly; rvalid arrives rv_dly
  // cycles after the first WAIT cycle. flush_cyc=0 means no flush.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                        input int flush_cyc, input logic [31:0] rdata);
    bit          st = is_store(op);
    bit          mis = model_misalign(op, addr);
    int          n_total = gnt_dly + rv_dly + 2;
    bit          timed_out = !mis && flush_cyc == 0 && n_total > TO;
    int          stray = timed_out ? TO + 2 : -1;
    int          exp_req, exp_done_cyc;
    bit          exp_err, exp_cause;
    int          got_req = 0, got_done = 0, got_done_cyc = -1;
    logic        got_err = 1'b0, got_cause = 1'b0, got_we = 1'b0, done_prev = 1'b0;
    logic [3:0]  got_strb = '0;
    logic [31:0] got_addr = '0, got_wdata = '0;

    if (mis) begin
      exp_req = 0; exp_done_cyc = 1; exp_err = 1; exp_cause = 0;
    end else if (flush_cyc > 0) begin
      exp_req = (flush_cyc < 1 + gnt_dly) ? flush_cyc : gnt_dly + 1;
      exp_done_cyc = -1; exp_err = 0; exp_cause = 0;
      if (!st && flush_cyc >= 1 + gnt_dly) exp_rdata = rdata;
    end else if (!timed_out) begin
      exp_req = gnt_dly + 1; exp_done_cyc = n_total + 1; exp_err = 0; exp_cause = 0;
      if (!st) exp_rdata = rdata;
    end else begin
      exp_req = (gnt_dly + 1 < TO) ? gnt_dly + 1 : TO;
      exp_done_cyc = TO + 1; exp_err = 1; exp_cause = 1;
    end

    @(negedge clk);
    lsu_vld = 1'b1; mem_op_i = op; addr_i = addr; wdata_i = wd; mem_wen = st;
    #1;
    check({nm, "_idle_busy"}, 32'(lsu_busy), 32'd0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done_prev || c == flush_cyc) lsu_vld = 1'b0;
      lsu_flush   = (c == flush_cyc);
      dmem_gnt    = (c == 1 + gnt_dly);
      dmem_rvalid = (c == n_total) || (c == stray);
      dmem_rdata  = (c == n_total) ? rdata : $urandom;
      #1;
      if (dmem_req) begin
        if (got_req == 0) begin
          got_addr = dmem_addr; got_we = dmem_we; got_strb = dmem_wstrb; got_wdata = dmem_wdata;
        end
        got_req++;
      end
      if (lsu_done) begin
        got_done++; got_done_cyc = c; got_err = lsu_err; got_cause = lsu_err_cause;
      end
      done_prev = lsu_done;
    end
    lsu_vld = 1'b0; lsu_flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

    check({nm, "_req_cycles"}, 32'(got_req), 32'(exp_req));
    if (exp_req > 0) begin
      check({nm, "_daddr"}, got_addr, addr - (addr % 4));
      check({nm, "_we"}, 32'(got_we), 32'(st));
      check({nm, "_strb"}, 32'(got_strb), 32'(model_strb(op, addr)));
      if (st) check({nm, "_wdata"}, got_wdata, model_wdata(op, wd));
    end
    check({nm, "_done_cnt"}, 32'(got_done), (flush_cyc > 0) ? 32'd0 : 32'd1);
    if (flush_cyc == 0) begin
      check({nm, "_done_cyc"}, 32'(got_done_cyc), 32'(exp_done_cyc));
      check({nm, "_err"}, 32'(got_err), 32'(exp_err));
      check({nm, "_cause"}, 32'(got_cause), 32'(exp_cause));
      check({nm, "_mem_op"}, 32'(mem_op), 32'(op));
      check({nm, "_mem_addr"}, mem_addr, addr);
      check({nm, "_mem_rdata"}, mem_rdata, exp_rdata);
    end
    check({nm, "_end_busy"}, 32'(lsu_busy), 32'd0);
  endtask

  logic [3:0] op_tab [8] = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("lw_basic", MEM_LW, 32'h100, 32'h0, 0, 1, 0, 32'hDEADBEEF);
    run_op("sb_lane3", MEM_SB, 32'h203, 32'h000000A5, 0, 0, 0, 32'h0);
    run_op("lh_misal", MEM_LH, 32'h101, 32'h0, 0, 0, 0, 32'h0);
    run_op("lw_nognt", MEM_LW, 32'h300, 32'h0, 99, 0, 0, 32'h12345678);
    run_op("sw_late",  MEM_SW, 32'h400, 32'hCAFEF00D, 3, 4, 0, 32'h0);
    run_op("lw_edge",  MEM_LW, 32'h404, 32'h0, 3, 3, 0, 32'h0BADF00D);
    run_op("sh_hi",    MEM_SH, 32'h40A, 32'h00001234, 1, 0, 0, 32'h0);
    run_op("lw_flreq", MEM_LW, 32'h500, 32'h0, 99, 0, 2, 32'h0);
    run_op("lw_flwt",  MEM_LW, 32'h504, 32'h0, 0, 3, 3, 32'h5555AAAA);
    run_op("lw_after", MEM_LW, 32'h508, 32'h0, 1, 0, 0, 32'h13579BDF);

    // Reset asserted while a load waits for its response.
    @(negedge clk);
    lsu_vld = 1'b1; mem_op_i = MEM_LW; addr_i = 32'h600; mem_wen = 1'b0;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    check("rst_wait_busy", 32'(lsu_busy), 32'd1);
    rst_n = 1'b0;
    lsu_vld = 1'b0;
    #1;
    check_all_zero("rst_wait");
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      run_op("rand", op_tab[$urandom_range(0, 7)], $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store controller in the MEM stage of the rvseed core. It takes a load or store from EX and checks alignment. It runs a req/gnt/rvalid transaction on the data-memory port, builds byte strobes and lane-shifted write data, and captures the raw read word. It then hands mem_op, mem_addr and mem_rdata to the register write-back mux, which does the load extraction and sign/zero extension.

Parameters:
TIMEOUT_CYC, 255, cycles allowed from entering REQ until rvalid before a bus error is flagged.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
lsu_vld  in  1  EX presents a memory op; held stable until lsu_done
lsu_flush  in  1  pipeline flush; kills the current op
mem_wen  in  1  1 = store, 0 = load
mem_op_i  in  `MEM_OP_WIDTH  MEM_LB/LH/LW/LBU/LHU, or MEM_SB/SH/SW
addr_i  in  `CPU_WIDTH  byte address (ALU result)
wdata_i  in  `CPU_WIDTH  store data (rs2), low-aligned
dmem_req  out  1  bus request
dmem_we  out  1  write enable
dmem_addr  out  `CPU_WIDTH  word address, {addr_i[31:2],2'b00}
dmem_wstrb  out  4  byte strobes
dmem_wdata  out  `CPU_WIDTH  lane-shifted store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  response valid (issued for loads and stores)
dmem_rdata  in  `CPU_WIDTH  read word
lsu_busy  out  1  state != IDLE
lsu_done  out  1  one-cycle completion pulse
lsu_err  out  1  valid with lsu_done: misalign or timeout
lsu_err_cause  out  1  0 = misaligned, 1 = bus timeout
mem_op  out  `MEM_OP_WIDTH  registered op, to write-back mux
mem_addr  out  `CPU_WIDTH  registered byte address
mem_rdata  out  `CPU_WIDTH  registered raw read word

Behaviour:
- Reset: state=IDLE. All outputs are 0, including mem_op=0, mem_addr=0, mem_rdata=0 and the timeout counter.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Accepts an op when lsu_vld=1 and lsu_flush=0.
  - On accept, registers mem_op, mem_addr and the store fields.
  - Misalignment: (H/HU/SH and addr[0]) or (W/SW and addr[1:0]!=0).
    - If misaligned: go to DONE with err=1, cause=0. No bus request is issued.
    - Otherwise go to REQ.
- REQ:
  - dmem_req=1; addr, we, wstrb and wdata are stable until gnt.
  - gnt → WAIT, and dmem_req drops the next cycle.
  - flush before gnt → IDLE, no done.
- WAIT: on rvalid, capture dmem_rdata into mem_rdata (loads only; stores keep the old value) → DONE.
- DONE: lsu_done=1 for exactly one cycle → IDLE. A new op can be accepted on the next cycle, so the minimum aligned latency is 4 cycles (IDLE → REQ → WAIT → DONE).
- Flush in WAIT: the FSM still waits for rvalid and drains, but suppresses lsu_done in DONE. An outstanding response is never orphaned.
- Flush in DONE: suppresses the pulse.
- Timeout counter:
  - Clears on entry to REQ and increments each REQ/WAIT cycle.
  - When it equals TIMEOUT_CYC: → DONE with err=1, cause=1. dmem_req drops.
  - A later stray rvalid is ignored.
  - rvalid and timeout in the same cycle: rvalid wins.
- Store lanes:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - SH: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata_i[15:0]}}.
  - SW: wstrb = 4'hF.
  - Loads: wstrb=0, we=0.
- mem_op, mem_addr and mem_rdata hold their values after DONE until the next accept.
- gnt in the same cycle as req entry is legal; single-cycle gnt and rvalid are legal.

Decomposition:
- MEM_SB/SH/SW codes are added alongside the existing `MEM_xx defines in the shared define file, with `CPU_WIDTH and `MEM_OP_WIDTH.
- Local FSM state encodings stay local parameters.
- Sub-module lsu_store_align: combinational op/addr/wdata → wstrb/wdata/misalign. Shared by the IDLE misalign check and the store-lane generation.

Test Plan:
- LW addr 0x100, gnt in cycle 1, rvalid 2 cycles later with 0xDEADBEEF → dmem_addr 0x100, one lsu_done, mem_rdata 0xDEADBEEF, err 0.
- SB addr 0x203, wdata_i 0x000000A5 → dmem_addr 0x200, wstrb 4'b1000, wdata 0xA5A5A5A5, we 1, done after rvalid.
- LH addr 0x101 → no dmem_req ever, lsu_done next cycle, err 1, cause 0.
- No gnt for TIMEOUT_CYC=8 (override) → done with err 1, cause 1 at cycle 8 after REQ entry. A later rvalid changes nothing.
- Flush during REQ (gnt held low) → IDLE, no done. Flush during WAIT → rvalid is consumed, no done, next LW completes normally.
- rst_n asserted in WAIT → all outputs 0 immediately, state IDLE.
